// File: rtl/spi_bus_switch_pkg.sv
// Shared types and helpers for the N-master SPI bus switch.
package spi_bus_switch_pkg;

    // Switch FSM states: connected, waiting for the current master to finish, forced idle gap.
    typedef enum logic [1:0] {
        StConn  = 2'd0,
        StDrain = 2'd1,
        StGuard = 2'd2
    } state_e;

    // Width of a counter that must be able to hold the value max_count.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/spi_lane_mux.sv
// N-way selector for the card-side cs/sclk/mosi lanes with a force-idle override,
// plus miso fan-out back to the selected master only.
module spi_lane_mux #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned SELW      = $clog2(N_MASTERS),
    parameter logic        SCLK_IDLE = 1'b0
) (
    input  logic [SELW-1:0]      sel_i,
    input  logic                 force_idle_i,
    input  logic [N_MASTERS-1:0] cs_i,
    input  logic [N_MASTERS-1:0] sclk_i,
    input  logic [N_MASTERS-1:0] mosi_i,
    output logic [N_MASTERS-1:0] miso_o,
    output logic                 cs_o,
    output logic                 sclk_o,
    output logic                 mosi_o,
    input  logic                 miso_i
);

    // Route the selected master to the card, or hold the bus idle; unselected masters read miso=1.
    always_comb begin
        cs_o   = 1'b1;
        sclk_o = SCLK_IDLE;
        mosi_o = 1'b1;
        miso_o = '1;
        if (!force_idle_i) begin
            for (int unsigned i = 0; i < N_MASTERS; i++) begin
                if (sel_i == SELW'(i)) begin
                    cs_o      = cs_i[i];
                    sclk_o    = sclk_i[i];
                    mosi_o    = mosi_i[i];
                    miso_o[i] = miso_i;
                end
            end
        end
    end

endmodule

// File: rtl/spi_bus_switch.sv
// N-master SPI bus switch: hands one shared card bus between masters with a
// drain-then-guard sequence so no master ever sees a partial transaction.
// Optional drain timeout enabled by defining SPI_BUS_SWITCH_TIMEOUT_EN.
module spi_bus_switch
    import spi_bus_switch_pkg::*;
#(
    parameter int unsigned N_MASTERS     = 2,
    parameter int unsigned SELW          = $clog2(N_MASTERS),
    parameter int unsigned GUARD_CYCLES  = 8,
    parameter logic        SCLK_IDLE     = 1'b0,
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] cs_i,
    input  logic [N_MASTERS-1:0] sclk_i,
    input  logic [N_MASTERS-1:0] mosi_i,
    output logic [N_MASTERS-1:0] miso_o,
    output logic                 cs_o,
    output logic                 sclk_o,
    output logic                 mosi_o,
    input  logic                 miso_i,
    input  logic [SELW-1:0]      sel_i,
    input  logic                 sel_valid_i,
    output logic [SELW-1:0]      active_sel_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 timeout_o
);

    localparam int unsigned   GCW       = cnt_width(GUARD_CYCLES);
    localparam logic [GCW-1:0] GuardLast = GCW'(GUARD_CYCLES - 1);

    state_e          state_q;
    logic [SELW-1:0] active_q;
    logic [SELW-1:0] target_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic [GCW-1:0]  guard_cnt_q;
    logic            force_idle;

`ifdef SPI_BUS_SWITCH_TIMEOUT_EN
    localparam int unsigned   DCW       = cnt_width(DRAIN_TIMEOUT);
    localparam logic [DCW-1:0] DrainLast = DCW'(DRAIN_TIMEOUT - 1);

    logic [DCW-1:0] drain_cnt_q;
    logic           timeout_q;
`endif

    // Reset forces the bus idle combinationally, before any clock edge arrives.
    assign force_idle = rst | (state_q == StGuard);

    spi_lane_mux #(
        .N_MASTERS (N_MASTERS),
        .SELW      (SELW),
        .SCLK_IDLE (SCLK_IDLE)
    ) u_lane_mux (
        .sel_i        (active_q),
        .force_idle_i (force_idle),
        .cs_i         (cs_i),
        .sclk_i       (sclk_i),
        .mosi_i       (mosi_i),
        .miso_o       (miso_o),
        .cs_o         (cs_o),
        .sclk_o       (sclk_o),
        .mosi_o       (mosi_o),
        .miso_i       (miso_i)
    );

    // Switch FSM with guard/drain counters and registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StConn;
            active_q    <= '0;
            target_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            guard_cnt_q <= '0;
`ifdef SPI_BUS_SWITCH_TIMEOUT_EN
            drain_cnt_q <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef SPI_BUS_SWITCH_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            unique case (state_q)
                StConn: begin
                    if (sel_valid_i && !busy_q) begin
                        if (32'(sel_i) >= N_MASTERS) begin
                            err_q <= 1'b1;
                        end else if (sel_i == active_q) begin
                            done_q <= 1'b1;
                        end else begin
                            target_q <= sel_i;
                            busy_q   <= 1'b1;
                            state_q  <= StDrain;
`ifdef SPI_BUS_SWITCH_TIMEOUT_EN
                            drain_cnt_q <= '0;
`endif
                        end
                    end
                end
                StDrain: begin
                    // Current master releasing cs marks the end of its transaction.
                    if (cs_i[active_q]) begin
                        state_q     <= StGuard;
                        guard_cnt_q <= '0;
`ifdef SPI_BUS_SWITCH_TIMEOUT_EN
                    end else if (drain_cnt_q == DrainLast) begin
                        state_q     <= StGuard;
                        guard_cnt_q <= '0;
                        timeout_q   <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
`endif
                    end
                end
                StGuard: begin
                    if (guard_cnt_q == GuardLast) begin
                        state_q  <= StConn;
                        active_q <= target_q;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        guard_cnt_q <= guard_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StConn;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign active_sel_o = active_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

`ifdef SPI_BUS_SWITCH_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    // Without the timeout feature the drain limit has no effect.
    logic unused_drain_timeout;
    assign unused_drain_timeout = ^DRAIN_TIMEOUT;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_bus_switch.sv
// Directed self-checking bench for spi_bus_switch (4 masters, 8 guard cycles).
module tb_spi_bus_switch;

    localparam int unsigned N    = 4;
    localparam int unsigned SW   = 3;
    localparam int unsigned G    = 8;
    localparam int unsigned DTMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  cs_i, sclk_i, mosi_i, miso_o;
    logic          cs_o, sclk_o, mosi_o, miso_i;
    logic [SW-1:0] sel_i, active_sel_o;
    logic          sel_valid_i, busy_o, done_o, err_o, timeout_o;
    logic [2:0]    bus;

    int n_checks = 0;
    int n_fail   = 0;

    assign bus = {cs_o, sclk_o, mosi_o};

    always #5 clk = ~clk;

    spi_bus_switch #(
        .N_MASTERS     (N),
        .SELW          (SW),
        .GUARD_CYCLES  (G),
        .SCLK_IDLE     (1'b0),
        .DRAIN_TIMEOUT (DTMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cs_i         (cs_i),
        .sclk_i       (sclk_i),
        .mosi_i       (mosi_i),
        .miso_o       (miso_o),
        .cs_o         (cs_o),
        .sclk_o       (sclk_o),
        .mosi_o       (mosi_o),
        .miso_i       (miso_i),
        .sel_i        (sel_i),
        .sel_valid_i  (sel_valid_i),
        .active_sel_o (active_sel_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .timeout_o    (timeout_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; sel_valid_i = 1'b0; sel_i = '0;
        cs_i = 4'b0000; sclk_i = 4'b1111; mosi_i = 4'b0000; miso_i = 1'b0;
        #1;
        n_checks++;
        if (bus !== 3'b101) begin n_fail++; $display("FAIL rst_bus got %b want 101", bus); end
        n_checks++;
        if (miso_o !== 4'b1111) begin n_fail++; $display("FAIL rst_miso got %b want 1111", miso_o); end
        tick; tick;
        n_checks++;
        if ({active_sel_o, busy_o, done_o, err_o, timeout_o} !== 7'b000_0000) begin
            n_fail++;
            $display("FAIL rst_regs got %b want 0000000",
                     {active_sel_o, busy_o, done_o, err_o, timeout_o});
        end
        rst = 1'b0; cs_i = 4'b1110; sclk_i = 4'b0001; mosi_i = 4'b0000;
        #1;
        n_checks++;
        if (bus !== 3'b010) begin n_fail++; $display("FAIL pass_m0_bus got %b want 010", bus); end
        n_checks++;
        if (miso_o !== 4'b1110) begin n_fail++; $display("FAIL pass_m0_miso got %b want 1110", miso_o); end
    endtask

    task automatic test_degenerate;
        sel_i = 3'd0; sel_valid_i = 1'b1;
        tick;
        sel_valid_i = 1'b0;
        n_checks++;
        if ({done_o, busy_o, err_o, active_sel_o} !== 6'b100_000) begin
            n_fail++; $display("FAIL same_sel got %b want 100000", {done_o, busy_o, err_o, active_sel_o});
        end
        tick;
        n_checks++;
        if (done_o !== 1'b0) begin n_fail++; $display("FAIL same_sel_pulse got %b want 0", done_o); end
        sel_i = 3'd5; sel_valid_i = 1'b1;
        tick;
        sel_valid_i = 1'b0;
        n_checks++;
        if ({err_o, done_o, busy_o, active_sel_o} !== 6'b100_000) begin
            n_fail++; $display("FAIL illegal_sel got %b want 100000", {err_o, done_o, busy_o, active_sel_o});
        end
        n_checks++;
        if (bus !== 3'b010) begin n_fail++; $display("FAIL illegal_bus got %b want 010", bus); end
        tick;
        n_checks++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse got %b want 0", err_o); end
    endtask

    task automatic test_idle_switch;
        cs_i = 4'b1011; sclk_i = 4'b0100; mosi_i = 4'b0000; miso_i = 1'b0;
        sel_i = 3'd2; sel_valid_i = 1'b1;
        tick;
        sel_valid_i = 1'b0;
        n_checks++;
        if ({busy_o, active_sel_o, bus} !== {1'b1, 3'd0, 3'b100}) begin
            n_fail++; $display("FAIL idle_drain got %b want 1000100", {busy_o, active_sel_o, bus});
        end
        tick;
        for (int i = 0; i < G; i++) begin
            n_checks++;
            if ({bus, miso_o, busy_o, done_o} !== {3'b101, 4'b1111, 2'b10}) begin
                n_fail++;
                $display("FAIL idle_guard[%0d] got %b want 101111110", i, {bus, miso_o, busy_o, done_o});
            end
            tick;
        end
        n_checks++;
        if ({active_sel_o, done_o, busy_o} !== {3'd2, 2'b10}) begin
            n_fail++; $display("FAIL idle_conn got %b want 01010", {active_sel_o, done_o, busy_o});
        end
        n_checks++;
        if ({bus, miso_o} !== {3'b010, 4'b1011}) begin
            n_fail++; $display("FAIL idle_conn_bus got %b want 0101011", {bus, miso_o});
        end
        tick;
        n_checks++;
        if (done_o !== 1'b0) begin n_fail++; $display("FAIL idle_done_pulse got %b want 0", done_o); end
    endtask

    task automatic test_busy_master;
        // Master 2 connected and busy; master 1 drives sclk=1, mosi=0 and must stay invisible.
        cs_i = 4'b1001; sclk_i = 4'b0010; mosi_i = 4'b0100; miso_i = 1'b0;
        sel_i = 3'd1; sel_valid_i = 1'b1;
        tick;
        sel_valid_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            n_checks++;
            if ({bus, miso_o, busy_o} !== {3'b001, 4'b1011, 1'b1}) begin
                n_fail++; $display("FAIL busy_drain[%0d] got %b want 00110111", i, {bus, miso_o, busy_o});
            end
            tick;
        end
        cs_i = 4'b1101;
        #1;
        n_checks++;
        if ({bus, miso_o} !== {3'b101, 4'b1011}) begin
            n_fail++; $display("FAIL busy_release got %b want 1011011", {bus, miso_o});
        end
        tick;
        for (int i = 0; i < G; i++) begin
            n_checks++;
            if ({bus, miso_o, busy_o} !== {3'b101, 4'b1111, 1'b1}) begin
                n_fail++; $display("FAIL busy_guard[%0d] got %b want 10111111", i, {bus, miso_o, busy_o});
            end
            if (i == G - 1) begin
                sel_i = 3'd3; sel_valid_i = 1'b1;
            end
            tick;
        end
        sel_valid_i = 1'b0;
        n_checks++;
        if ({active_sel_o, done_o, busy_o, bus, miso_o} !== {3'd1, 2'b10, 3'b010, 4'b1101}) begin
            n_fail++;
            $display("FAIL busy_conn got %b want 001100101101", {active_sel_o, done_o, busy_o, bus, miso_o});
        end
        tick;
        n_checks++;
        if ({busy_o, active_sel_o} !== {1'b0, 3'd1}) begin
            n_fail++; $display("FAIL done_edge_req got %b want 0001", {busy_o, active_sel_o});
        end
    endtask

    task automatic test_ignored;
        cs_i = 4'b1101;
        sel_i = 3'd3; sel_valid_i = 1'b1;
        tick;
        sel_valid_i = 1'b0;
        tick;
        sel_i = 3'd2; sel_valid_i = 1'b1;
        tick;
        sel_valid_i = 1'b0;
        n_checks++;
        if ({busy_o, active_sel_o, done_o, err_o} !== {1'b1, 3'd1, 2'b00}) begin
            n_fail++; $display("FAIL drain_req got %b want 100100", {busy_o, active_sel_o, done_o, err_o});
        end
        cs_i = 4'b1111;
        tick;
        n_checks++;
        if (miso_o !== 4'b1111) begin n_fail++; $display("FAIL ign_guard got %b want 1111", miso_o); end
        sel_i = 3'd0; sel_valid_i = 1'b1;
        tick;
        sel_valid_i = 1'b0;
        tick;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus, miso_o} !== {3'b101, 4'b1111}) begin
            n_fail++; $display("FAIL mid_rst_bus got %b want 1011111", {bus, miso_o});
        end
        tick;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if ({active_sel_o, busy_o, done_o} !== 5'b000_00) begin
                n_fail++; $display("FAIL post_rst[%0d] got %b want 00000", i, {active_sel_o, busy_o, done_o});
            end
            tick;
        end
    endtask

`ifdef SPI_BUS_SWITCH_TIMEOUT_EN
    task automatic test_timeout;
        cs_i = 4'b1110; sclk_i = 4'b0000; mosi_i = 4'b0000; miso_i = 1'b0;
        sel_i = 3'd1; sel_valid_i = 1'b1;
        tick;
        sel_valid_i = 1'b0;
        for (int i = 0; i < DTMO; i++) begin
            n_checks++;
            if ({timeout_o, busy_o, miso_o} !== {2'b01, 4'b1110}) begin
                n_fail++; $display("FAIL tmo_drain[%0d] got %b want 011110", i, {timeout_o, busy_o, miso_o});
            end
            tick;
        end
        n_checks++;
        if ({timeout_o, miso_o} !== {1'b1, 4'b1111}) begin
            n_fail++; $display("FAIL tmo_pulse got %b want 11111", {timeout_o, miso_o});
        end
        tick;
        for (int i = 0; i < G - 1; i++) begin
            n_checks++;
            if ({timeout_o, miso_o, done_o} !== {1'b0, 4'b1111, 1'b0}) begin
                n_fail++; $display("FAIL tmo_guard[%0d] got %b want 011110", i, {timeout_o, miso_o, done_o});
            end
            tick;
        end
        n_checks++;
        if ({done_o, active_sel_o, busy_o} !== {1'b1, 3'd1, 1'b0}) begin
            n_fail++; $display("FAIL tmo_done got %b want 10010", {done_o, active_sel_o, busy_o});
        end
    endtask
`else
    task automatic test_timeout;
        // Master 0 never releases cs: the switch must stay in drain with timeout_o low.
        cs_i = 4'b1110; miso_i = 1'b0;
        sel_i = 3'd1; sel_valid_i = 1'b1;
        tick;
        sel_valid_i = 1'b0;
        for (int i = 0; i < 40; i++) tick;
        n_checks++;
        if ({timeout_o, busy_o, done_o, miso_o} !== {3'b010, 4'b1110}) begin
            n_fail++; $display("FAIL no_tmo got %b want 0101110", {timeout_o, busy_o, done_o, miso_o});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_degenerate();
        test_idle_switch();
        test_busy_master();
        test_ignored();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
